// File: rtl/muldiv_pkg.sv
// Shared op codes, ALU op constants, FSM states and sign helpers for the
// mult/div sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_MULT  = 4'b0110;
  localparam logic [3:0] ALU_MULTU = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } state_t;

  // Two's complement negate when neg is set; also yields magnitude of a negative value.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Pipeline-side bundle of the mult/div unit: operation launch, HI/LO moves,
// architectural HI/LO and the busy/done handshake.
interface muldiv_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and restore on underflow.
module div_step (
  input  logic [32:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [32:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] shifted_s;
  logic [32:0] diff_s;

  // Remainder stays below the divisor, so its low 32 bits hold it and bit 32 of diff is the sign.
  always_comb begin
    shifted_s = {rem[31:0], quo[31]};
    diff_s    = shifted_s - {1'b0, divisor};
    if (diff_s[32]) begin
      rem_next = shifted_s;
      quo_next = {quo[30:0], 1'b0};
    end else begin
      rem_next = diff_s;
      quo_next = {quo[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for mult/multu/div/divu/mthi/mtlo: one-cycle
// multiplies through an external ALU, 32-cycle restoring divide in-house.
import muldiv_pkg::*;

module muldiv_ctrl #(
  parameter int DIV_ITERS = 32'd32
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_ctrl_if.slave      bus,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [3:0]        alu_op,
  input  logic [31:0]       alu_hi,
  input  logic [31:0]       alu_lo
);

  localparam int CNT_W = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 32'd1);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [32:0]       rem_r, rem_step_s;
  logic [31:0]       quo_r, quo_step_s, dvsr_r;
  logic              neg_q_r, neg_r_r, dz_r;
  logic [31:0]       hi_r, lo_r, alu_a_r, alu_b_r;
  logic [3:0]        alu_op_r;
  logic              busy_r, done_r, div_zero_r;
  logic              accept_s, is_mul_s, sgn_s;
  logic [31:0]       q_fix_s, r_fix_s;

  div_step u_div_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (dvsr_r),
    .rem_next (rem_step_s),
    .quo_next (quo_step_s)
  );

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    is_mul_s = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    sgn_s    = (bus.op == OP_DIV);
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          accept_s = 1'b1;
          if (is_mul_s) begin
            state_s = MUL;
          end else if (bus.b == 32'd0) begin
            state_s = FIX;
          end else begin
            state_s = DIV;
          end
        end else begin
          state_s = IDLE;
        end
      end
      MUL:     state_s = IDLE;
      DIV: begin
        if (cnt_r == CNT_LAST) begin
          state_s = FIX;
        end else begin
          state_s = DIV;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Sign correction applied to the unsigned quotient/remainder in FIX.
  always_comb begin
    q_fix_s = cond_neg(quo_r, neg_q_r);
    r_fix_s = cond_neg(rem_r[31:0], neg_r_r);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, HI/LO and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= '0;
      rem_r      <= 33'd0;
      quo_r      <= 32'd0;
      dvsr_r     <= 32'd0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      dz_r       <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      alu_a_r    <= 32'd0;
      alu_b_r    <= 32'd0;
      alu_op_r   <= ALU_ADD;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      busy_r     <= (state_s != IDLE);
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      alu_a_r    <= 32'd0;
      alu_b_r    <= 32'd0;
      alu_op_r   <= ALU_ADD;
      case (state_r)
        IDLE: begin
          if (accept_s && is_mul_s) begin
            alu_a_r  <= bus.a;
            alu_b_r  <= bus.b;
            alu_op_r <= (bus.op == OP_MULTU) ? ALU_MULTU : ALU_MULT;
          end else if (accept_s) begin
            rem_r   <= 33'd0;
            quo_r   <= cond_neg(bus.a, sgn_s & bus.a[31]);
            dvsr_r  <= cond_neg(bus.b, sgn_s & bus.b[31]);
            neg_q_r <= sgn_s & (bus.a[31] ^ bus.b[31]);
            neg_r_r <= sgn_s & bus.a[31];
            dz_r    <= (bus.b == 32'd0);
            cnt_r   <= '0;
          end else begin
            if (bus.mthi) hi_r <= bus.wdata;
            if (bus.mtlo) lo_r <= bus.wdata;
          end
        end
        MUL: begin
          hi_r   <= alu_hi;
          lo_r   <= alu_lo;
          done_r <= 1'b1;
        end
        DIV: begin
          rem_r <= rem_step_s;
          quo_r <= quo_step_s;
          cnt_r <= cnt_r + CNT_W'(1);
        end
        FIX: begin
          done_r <= 1'b1;
          if (dz_r) begin
            div_zero_r <= 1'b1;
          end else begin
            lo_r <= q_fix_s;
            hi_r <= r_fix_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a        = alu_a_r;
  assign alu_b        = alu_b_r;
  assign alu_op       = alu_op_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural multiplier standing in
// for the ALU; expected values are hand-computed constants.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_a, alu_b, alu_hi, alu_lo;
  logic [3:0]  alu_op;
  logic [63:0] prod;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          n;
  logic        seen;

  muldiv_ctrl_if bus();

  muldiv_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op),
    .alu_hi (alu_hi),
    .alu_lo (alu_lo)
  );

  always #5 clk = ~clk;

  // ALU stand-in: 64-bit product of the operands.
  always_comb begin
    case (alu_op)
      4'b0110: prod = {{32{alu_a[31]}}, alu_a} * {{32{alu_b[31]}}, alu_b};
      4'b0111: prod = {32'd0, alu_a} * {32'd0, alu_b};
      default: prod = 64'd0;
    endcase
    alu_hi = prod[63:32];
    alu_lo = prod[31:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Counts busy cycles after the launch edge, bounded.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 60) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'd0; bus.b = 32'd0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = 32'd0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", bus.busy, 32'd0);
    chk("rst_done", bus.done, 32'd0);
    chk("rst_dz", bus.div_zero, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_aluop", alu_op, 32'h4);

    // multu 0xFFFFFFFF * 2
    launch(2'b01, 32'hFFFF_FFFF, 32'd2);
    chk("multu_busy", bus.busy, 32'd1);
    chk("multu_aluop", alu_op, 32'h7);
    chk("multu_alua", alu_a, 32'hFFFF_FFFF);
    chk("multu_done_early", bus.done, 32'd0);
    chk("multu_hi_held", bus.hi, 32'd0);
    tick();
    chk("multu_busy_end", bus.busy, 32'd0);
    chk("multu_done", bus.done, 32'd1);
    chk("multu_hi", bus.hi, 32'h0000_0001);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFE);
    chk("idle_aluop", alu_op, 32'h4);

    // mult -3 * 5, launched back-to-back in the done cycle
    launch(2'b00, 32'hFFFF_FFFD, 32'd5);
    chk("mult_aluop", alu_op, 32'h6);
    chk("mult_done_cleared", bus.done, 32'd0);
    tick();
    chk("mult_done", bus.done, 32'd1);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFF1);

    // Preload HI/LO then divu by zero leaves them alone
    bus.mthi = 1'b1; bus.wdata = 32'h11; tick();
    bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = 32'h22; tick();
    bus.mtlo = 1'b0;
    chk("mthi", bus.hi, 32'h11);
    chk("mtlo", bus.lo, 32'h22);
    launch(2'b11, 32'd100, 32'd0);
    chk("dz_busy", bus.busy, 32'd1);
    chk("dz_done_early", bus.done, 32'd0);
    tick();
    chk("dz_busy_end", bus.busy, 32'd0);
    chk("dz_done", bus.done, 32'd1);
    chk("dz_flag", bus.div_zero, 32'd1);
    chk("dz_hi", bus.hi, 32'h11);
    chk("dz_lo", bus.lo, 32'h22);
    tick();
    chk("dz_flag_pulse", bus.div_zero, 32'd0);
    chk("dz_done_pulse", bus.done, 32'd0);

    // start with mthi in the same idle cycle: start wins
    bus.mthi = 1'b1; bus.wdata = 32'hBAD0_BAD0;
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    bus.mthi = 1'b0;
    chk("mt_dropped", bus.hi, 32'h11);
    tick(); tick(); tick();
    chk("div_hi_held", bus.hi, 32'h11);
    chk("div_lo_held", bus.lo, 32'h22);
    wait_idle(n);
    chk("div_busy_cycles", n + 3, 32'd33);
    chk("div_done", bus.done, 32'd1);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    chk("div_nz", bus.div_zero, 32'd0);

    launch(2'b11, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_busy_cycles", n, 32'd33);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);

    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("ovf_done", bus.done, 32'd1);
    chk("ovf_lo", bus.lo, 32'h8000_0000);
    chk("ovf_hi", bus.hi, 32'd0);
    chk("ovf_nz", bus.div_zero, 32'd0);

    // Abort: ignored start/mthi mid-divide, then reset mid-divide
    launch(2'b11, 32'd1000, 32'd3);
    tick(); tick(); tick(); tick();
    bus.start = 1'b1; bus.op = 2'b00; bus.mthi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    tick();
    bus.start = 1'b0; bus.mthi = 1'b0;
    chk("abort_busy", bus.busy, 32'd1);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_aluop", alu_op, 32'h4);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_rst_busy", bus.busy, 32'd0);
    chk("abort_rst_lo", bus.lo, 32'd0);
    chk("abort_rst_hi", bus.hi, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.busy) seen = 1'b1;
      tick();
    end
    chk("abort_no_done", seen, 32'd0);
    chk("abort_lo_stays", bus.lo, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer and HI/LO register owner for MIPS mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- Drives a dedicated ALU instance for one-cycle multiplies; runs a 32-iteration restoring divider internally.
- Presents architectural HI/LO plus a busy/done handshake to the pipeline; the pipeline stalls mfhi/mflo and new mul/div ops while busy.

Parameters:
- DIV_ITERS, 32, number of divide iterations; equals operand width, fixed at 32 in this design.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  launch operation in op (single-cycle pulse)
- op  in  2  00 mult, 01 multu, 10 div, 11 divu
- a  in  32  rs operand / dividend
- b  in  32  rt operand / divisor
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  32  mthi/mtlo data
- alu_a  out  32  to ALU a
- alu_b  out  32  to ALU b
- alu_op  out  4  to ALU op
- alu_hi  in  32  ALU hi result
- alu_lo  in  32  ALU lo result
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  operation in flight
- done  out  1  one-cycle completion pulse
- div_zero  out  1  one-cycle pulse: divide by zero

Behaviour:
- Clock and reset: clk, rst; one clock domain, reset synchronous active-high.
- Reset (including mid-operation): state IDLE; hi=lo=0; busy=done=div_zero=0; iteration counter 0. Any in-flight result is discarded.
- States: IDLE, MUL, DIV, FIX.
- Operand latching: start is sampled only in IDLE. a, b and op are latched at that edge. start while busy is ignored with no error.
- Edge numbering: k is the rising edge that samples start.
- MUL:
  - Entered at edge k.
  - alu_a/alu_b = latched a/b; alu_op = 4'b0110 (mult) or 4'b0111 (multu).
  - At edge k+1: hi<=alu_hi, lo<=alu_lo, state IDLE.
  - busy=1 only in the cycle after edge k; done=1 in the cycle after edge k+1.
- ALU outputs outside MUL: alu_op=4'b0100, alu_a=alu_b=0.
- DIV, b!=0:
  - Signed op: operands converted to magnitudes.
  - 33-bit partial remainder; 32 iterations, one per cycle, MSB first.
  - Each iteration: shift, trial subtract, restore if negative, set quotient bit.
  - Then FIX for one cycle. Quotient negated if signs differ (signed only). Remainder takes the dividend sign.
  - At the edge ending FIX: lo<=quotient, hi<=remainder.
  - busy=1 for 33 cycles (32 DIV + 1 FIX); done in the 34th cycle after edge k.
- DIV, b==0: go directly to FIX without iterating. hi/lo unchanged; done and div_zero both pulse; busy lasts 1 cycle.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap, no flag).
- mthi/mtlo:
  - Honored only in IDLE with no start; written at that edge. Both asserted writes both registers.
  - Ignored while busy.
  - start in the same cycle takes priority; the mt write is dropped.
- Outputs: hi/lo are registered and never change mid-operation; the old values stay visible until the completion edge. done and div_zero are registered pulses of exactly one cycle.
- Back-to-back: start is accepted in the same cycle that done is high, since state is IDLE.

Decomposition:
- muldiv_pkg holds:
  - op codes: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - ALU op constants: ALU_ADD=4'b0100, ALU_MULT=4'b0110, ALU_MULTU=4'b0111
  - state enum: IDLE, MUL, DIV, FIX
- Sub-module div_step: combinational single restoring iteration. Inputs: remainder, quotient, divisor. Outputs: next remainder, next quotient.

Test Plan:
- multu a=0xFFFFFFFF b=2 -> busy 1 cycle; hi=0x00000001, lo=0xFFFFFFFE, done pulse at k+1 cycle; alu_op=0111 during MUL.
- mult a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- div a=0xFFFFFFF9 (-7) b=2 -> busy 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 100/7 -> lo=14, hi=2.
- divu a=100 b=0 with hi=0x11, lo=0x22 preloaded via mthi/mtlo -> div_zero+done pulse after 1 busy cycle; hi=0x11, lo=0x22 unchanged.
- div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Start divu, then on iteration 5 assert start and mthi (both ignored); on iteration 10 assert rst -> next cycle busy=0, hi=lo=0, no done pulse.
